maze_env: RTL

Parametrised grid-world environment engine for the Q-learning datapath. It accepts one action per handshake, moves an agent on a ROWS×COLS maze, and returns next state, signed reward and a terminal flag. It tracks step and episode counters and restarts episodes on its own. It replaces hand-written behavioural reward logic, so the accelerator can train in closed loop on silicon.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_move.sv | 35 +++
 rtl/maze_env.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared types and defaults for the grid-world environment engine.
package maze_pkg;

    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RESTART = 2'd3
    } fsm_e;

    localparam int DEF_R_GOAL    = 100;
    localparam int DEF_R_TRAP    = -100;
    localparam int DEF_R_TIMEOUT = -50;

    // Default 5x5 trap layout: states 3,4,7,13,14,17,19,22 (bit i = state i+1)
    localparam int unsigned DEF_CELLS = 25;
    localparam logic [DEF_CELLS-1:0] DEF_TRAP_MASK = 25'h025304C;

    // Register width able to hold an index in [0, n-1]
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maze_move.sv
// Combinational single-step move on the grid: row/col update with wall clamp
// and the resulting 1-based row-major state number.
module maze_move
    import maze_pkg::*;
#(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5,
    parameter int unsigned SW   = 6,
    parameter int unsigned RWD  = idx_width(ROWS),
    parameter int unsigned CWD  = idx_width(COLS)
) (
    input  logic [RWD-1:0] row,
    input  logic [CWD-1:0] col,
    input  logic [1:0]     action,
    output logic [RWD-1:0] new_row_c,
    output logic [CWD-1:0] new_col_c,
    output logic [SW-1:0]  new_state_c
);

    // Off-grid moves leave the coordinate unchanged
    always_comb begin
        new_row_c = row;
        new_col_c = col;
        case (action_e'(action))
            ACT_UP:    if (row != '0)               new_row_c = row - RWD'(1);
            ACT_RIGHT: if (col != CWD'(COLS - 1))   new_col_c = col + CWD'(1);
            ACT_DOWN:  if (row != RWD'(ROWS - 1))   new_row_c = row + RWD'(1);
            ACT_LEFT:  if (col != '0)               new_col_c = col - CWD'(1);
            default:   ;
        endcase
    end

    assign new_state_c = SW'(new_row_c) * SW'(COLS) + SW'(new_col_c) + SW'(1);

endmodule

// File: rtl/maze_env.sv
// Grid-world environment engine: accepts one action per handshake, returns
// next state, signed reward and terminal flag, and restarts episodes itself.
module maze_env
    import maze_pkg::*;
#(
    parameter int unsigned ROWS      = 5,
    parameter int unsigned COLS      = 5,
    parameter int unsigned SW        = 6,
    parameter int unsigned RW        = 16,
    parameter int unsigned STW       = 8,
    parameter int unsigned EPW       = 16,
    parameter int unsigned MAX_STEPS = 15,
    parameter int unsigned START     = 1,
    parameter int unsigned GOAL      = 25,
    parameter logic [ROWS*COLS-1:0] TRAP_MASK = (ROWS*COLS)'(DEF_TRAP_MASK),
    parameter int          R_GOAL    = DEF_R_GOAL,
    parameter int          R_TRAP    = DEF_R_TRAP,
    parameter int          R_TIMEOUT = DEF_R_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           act_valid,
    output logic           act_ready,
    input  logic [1:0]     action,
    output logic [SW-1:0]  state,
    output logic           res_valid,
    output logic [SW-1:0]  next_state,
    output logic [RW-1:0]  reward,
    output logic           done,
    output logic [STW-1:0] step_count,
    output logic [EPW-1:0] episode_count
);

    localparam int unsigned RWD    = idx_width(ROWS);
    localparam int unsigned CWD    = idx_width(COLS);
    localparam int unsigned NSTATE = 1 << SW;

    localparam logic [RWD-1:0] START_ROW = RWD'((START - 1) / COLS);
    localparam logic [CWD-1:0] START_COL = CWD'((START - 1) % COLS);
    localparam logic [SW-1:0]  START_ST  = SW'(START);
    localparam logic [SW-1:0]  GOAL_ST   = SW'(GOAL);

    // Trap bit indexed directly by the 1-based state number
    localparam logic [NSTATE-1:0] TRAP_BY_STATE = NSTATE'({TRAP_MASK, 1'b0});

    localparam logic [RW-1:0] RWD_GOAL    = RW'(R_GOAL);
    localparam logic [RW-1:0] RWD_TRAP    = RW'(R_TRAP);
    localparam logic [RW-1:0] RWD_TIMEOUT = RW'(R_TIMEOUT);

    fsm_e           fsm_q, fsm_d;
    logic [RWD-1:0] row_q;
    logic [CWD-1:0] col_q;
    logic [RWD-1:0] mv_row;
    logic [CWD-1:0] mv_col;
    logic [SW-1:0]  mv_state;
    logic [STW-1:0] step_inc;
    logic           accept;
    logic           goal_hit, timeout_hit, trap_hit;
    logic [RW-1:0]  res_reward;
    logic           res_done;

    maze_move #(
        .ROWS (ROWS),
        .COLS (COLS),
        .SW   (SW),
        .RWD  (RWD),
        .CWD  (CWD)
    ) u_move (
        .row         (row_q),
        .col         (col_q),
        .action      (action),
        .new_row_c   (mv_row),
        .new_col_c   (mv_col),
        .new_state_c (mv_state)
    );

    // Handshake must follow en in the same cycle, so this one is combinational
    assign act_ready = (fsm_q == ST_READY) && en;
    assign accept    = act_ready && act_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (en) fsm_d = ST_READY;
            end
            ST_READY: begin
                if (!en)         fsm_d = ST_IDLE;
                else if (accept) fsm_d = ST_RESP;
            end
            ST_RESP:    fsm_d = done ? ST_RESTART : ST_READY;
            ST_RESTART: fsm_d = ST_READY;
            default:    fsm_d = ST_IDLE;
        endcase
    end

    // Reward priority: goal, then step budget, then trap
    always_comb begin
        step_inc    = step_count + STW'(1);
        goal_hit    = (mv_state == GOAL_ST);
        timeout_hit = (step_inc == STW'(MAX_STEPS));
        trap_hit    = TRAP_BY_STATE[mv_state];
        res_reward  = '0;
        res_done    = 1'b0;
        if (goal_hit) begin
            res_reward = RWD_GOAL;
            res_done   = 1'b1;
        end else if (timeout_hit) begin
            res_reward = RWD_TIMEOUT;
            res_done   = 1'b1;
        end else if (trap_hit) begin
            res_reward = RWD_TRAP;
            res_done   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= START_ROW;
            col_q         <= START_COL;
            state         <= START_ST;
            next_state    <= START_ST;
            reward        <= '0;
            done          <= 1'b0;
            res_valid     <= 1'b0;
            step_count    <= '0;
            episode_count <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                row_q      <= mv_row;
                col_q      <= mv_col;
                state      <= mv_state;
                next_state <= mv_state;
                reward     <= res_reward;
                done       <= res_done;
                step_count <= step_inc;
            end
            if (fsm_q == ST_RESTART) begin
                row_q         <= START_ROW;
                col_q         <= START_COL;
                state         <= START_ST;
                step_count    <= '0;
                episode_count <= episode_count + EPW'(1);
            end
        end
    end

endmodule
